// File: rtl/mem_copy_engine_pkg.sv
// Shared types for the byte-serial memory copy engine (optional MEM_COPY_CHECKSUM_EN build).
package mem_copy_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the copy engine; master is the engine, slave is the memory.
interface mem_copy_engine_if
  import mem_copy_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) ();

  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_copy_engine_csum.sv
// Running mod-2^N sum of written bytes; only instantiated under MEM_COPY_CHECKSUM_EN.
module mem_copy_csum
  import mem_copy_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] data,
  output logic [N-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Forward byte-serial memory copy engine (RD/WR per byte).
// Define MEM_COPY_CHECKSUM_EN to add the checksum output.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       src,
  input  logic [N-1:0]       dst,
  input  logic [N-1:0]       len,
  output logic               busy,
  output logic               done,
  mem_copy_engine_if.master  mem
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [N-1:0]       checksum
`endif
);

  state_t       state;
  logic [N-1:0] src_q;
  logic [N-1:0] dst_q;
  logic [N-1:0] len_q;
  logic [N-1:0] idx;
  logic         we_q;
  logic [N-1:0] addr_q;
  logic [N:0]   idx_nxt;

  // One extra bit so idx+1 never wraps before comparing against len.
  assign idx_nxt = {1'b0, idx} + (N+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              src_q  <= src;
              dst_q  <= dst;
              len_q  <= len;
              idx    <= '0;
              busy   <= 1'b1;
              addr_q <= src;
              state  <= RD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RD: begin
          we_q   <= 1'b1;
          addr_q <= dst_q + idx;
          state  <= WR;
        end
        WR: begin
          idx  <= idx_nxt[N-1:0];
          we_q <= 1'b0;
          if (idx_nxt < {1'b0, len_q}) begin
            addr_q <= src_q + idx_nxt[N-1:0];
            state  <= RD;
          end else begin
            addr_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data returns in the WR cycle, so write data is a pass-through.
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = (state == WR) ? mem.mem_rdata : '0;

`ifdef MEM_COPY_CHECKSUM_EN
  mem_copy_csum #(
    .N(N)
  ) u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE && start),
    .en    (we_q),
    .data  (mem.mem_wdata),
    .sum   (checksum)
  );
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a sequential byte-copy model.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] src, dst, len;
  logic         busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [N-1:0] checksum;
`endif

  mem_copy_engine_if #(.N(N)) bus ();

  mem_copy_engine #(
    .N(N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .mem   (bus)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [N-1:0] mem_arr [256];
  logic [N-1:0] ref_mem [256];
  logic         load_en;
  logic [N-1:0] load_addr, load_data;

  always @(posedge clk) begin
    if (load_en) mem_arr[load_addr] <= load_data;
    else if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [N-1:0] a, input logic [N-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 256; i++) begin
      check(tag, 32'(mem_arr[i]), 32'(ref_mem[i]));
    end
  endtask

  task automatic run_copy(input logic [N-1:0] s, input logic [N-1:0] d,
                          input logic [N-1:0] l, input bit poke_busy);
    int n, bc, wc;
    logic [N-1:0] exp_sum;
    logic [N-1:0] sa, da;
    exp_sum = '0;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + N'(i);
      da = d + N'(i);
      ref_mem[da] = ref_mem[sa];
      exp_sum = exp_sum + ref_mem[sa];
    end
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 1'b0;
    src = N'($urandom); dst = N'($urandom); len = N'($urandom);
    n = 1; bc = 0; wc = 0;
    while (!done && n < 700) begin
      if (busy) bc++;
      if (bus.mem_we) wc++;
      if (poke_busy && n == 3) begin
        start = 1'b1;
        src = s + 8'h40;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_latency", 32'(n), (l == '0) ? 32'd1 : 32'(2 * int'(l) + 1));
    check("busy_cycles", 32'(bc), 32'(2 * int'(l)));
    check("we_cycles", 32'(wc), 32'(l));
    check("busy_at_done", 32'(busy), 32'd0);
    check("we_at_done", 32'(bus.mem_we), 32'd0);
    check("addr_at_done", 32'(bus.mem_addr), 32'd0);
    check("wdata_at_done", 32'(bus.mem_wdata), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(exp_sum));
`endif
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    compare_mem("mem");
  endtask

  initial begin
    logic [N-1:0] s, d, l;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) poke(N'(i), N'($urandom));

    poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
    run_copy(8'h10, 8'h80, 8'd4, 1'b0);
    check("dir_80", 32'(mem_arr[8'h80]), 32'hAA);
    check("dir_83", 32'(mem_arr[8'h83]), 32'hDD);

    run_copy(8'h20, 8'h30, 8'd0, 1'b0);

    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    run_copy(8'hFE, 8'h01, 8'd3, 1'b0);
    check("wrap_03", 32'(mem_arr[8'h03]), 32'h33);

    run_copy(8'h30, 8'h60, 8'd5, 1'b1);

    poke(8'h40, 8'hF0); poke(8'h41, 8'h20);
    run_copy(8'h40, 8'h50, 8'd2, 1'b0);

    // Reset during the RD that follows the second write of a 4-byte copy.
    start = 1'b1; src = 8'hA0; dst = 8'hC0; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_we", 32'(bus.mem_we), 32'd0);
    check("abort_addr", 32'(bus.mem_addr), 32'd0);
    check("abort_wdata", 32'(bus.mem_wdata), 32'd0);
    ref_mem[8'hC0] = ref_mem[8'hA0];
    ref_mem[8'hC1] = ref_mem[8'hA1];
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    compare_mem("abort_mem");

    for (int t = 0; t < 20; t++) begin
      s = N'($urandom);
      d = ($urandom_range(0, 1) == 0) ? N'($urandom) : s + N'($urandom_range(0, 6));
      l = N'($urandom_range(0, 16));
      run_copy(s, d, l, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
